clock_time_setter: RTL

Upstream time-keeping and setting stage for the eight-digit HH:MM:SS display scanner. It holds the 24-hour time in binary fields and advances it on an external 1 Hz tick. It also runs a key-driven edit FSM (mode/inc/dec) with auto-repeat and field blinking. The display stage consumes o_hh/o_mm/o_ss and blanks digits per o_blank.

---
 rtl/clock_time_setter_pkg.sv | 41 ++++
 rtl/clock_time_setter_key_repeat.sv | 39 +++
 rtl/clock_time_setter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/clock_time_setter_pkg.sv
// Shared types, field bounds and wrap helpers for the time setter.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_SET_HH = 2'd1,
    MODE_SET_MM = 2'd2,
    MODE_SET_SS = 2'd3
  } mode_t;

  localparam int unsigned HH_MAX = 23;
  localparam int unsigned MM_MAX = 59;
  localparam int unsigned SS_MAX = 59;
  localparam int unsigned HH_W   = 5;
  localparam int unsigned MS_W   = 6;

  // Mode key advances RUN -> SET_HH -> SET_MM -> SET_SS -> RUN.
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_RUN:    return MODE_SET_HH;
      MODE_SET_HH: return MODE_SET_MM;
      MODE_SET_MM: return MODE_SET_SS;
      default:     return MODE_RUN;
    endcase
  endfunction

  // Hour edit step with 23 <-> 0 wrap; zero is caught by compare, never underflow.
  function automatic logic [HH_W-1:0] step_hh(input logic [HH_W-1:0] v, input logic up);
    if (up) return (v == HH_W'(HH_MAX)) ? '0 : v + HH_W'(1);
    else    return (v == '0) ? HH_W'(HH_MAX) : v - HH_W'(1);
  endfunction

  // Minute/second edit step with max <-> 0 wrap.
  function automatic logic [MS_W-1:0] step_ms(input logic [MS_W-1:0] v,
                                              input logic [MS_W-1:0] max,
                                              input logic up);
    if (up) return (v == max) ? '0 : v + MS_W'(1);
    else    return (v == '0) ? max : v - MS_W'(1);
  endfunction

endpackage

// File: rtl/clock_time_setter_key_repeat.sv
// Press detection plus auto-repeat for one debounced key.
module key_repeat #(
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 6250000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_step
);

  localparam int unsigned CW = $clog2(REPEAT_DELAY + 1);

  logic          key_q;
  logic [CW-1:0] cnt;
  logic          press;
  logic          repeat_hit;

  // cnt holds the number of cycles since the press; after the first repeat it is
  // reloaded so that it reaches REPEAT_DELAY again every REPEAT_PERIOD cycles.
  assign press      = i_key & ~key_q;
  assign repeat_hit = i_key & key_q & (cnt == CW'(REPEAT_DELAY));
  assign o_step     = press | repeat_hit;

  // Key history and hold counter; release clears the counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      key_q <= 1'b0;
      cnt   <= '0;
    end else begin
      key_q <= i_key;
      if (!i_key)          cnt <= '0;
      else if (press)      cnt <= CW'(1);
      else if (repeat_hit) cnt <= CW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
      else                 cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/clock_time_setter.sv
// 24-hour time keeper with key-driven field editing, auto-repeat and blinking.
module clock_time_setter
  import clock_pkg::*;
#(
  parameter int unsigned F_CLK         = 50000000,
  parameter int unsigned BLINK_HZ      = 2,
  parameter int unsigned REPEAT_DELAY  = F_CLK / 2,
  parameter int unsigned REPEAT_PERIOD = F_CLK / 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_tick_1hz,
  input  logic            i_key_mode,
  input  logic            i_key_inc,
  input  logic            i_key_dec,
  output logic [HH_W-1:0] o_hh,
  output logic [MS_W-1:0] o_mm,
  output logic [MS_W-1:0] o_ss,
  output logic [1:0]      o_mode,
  output logic [2:0]      o_blank,
  output logic            o_day_pulse
);

  localparam int unsigned HALF = F_CLK / (2 * BLINK_HZ);
  localparam int unsigned BW   = (HALF > 1) ? $clog2(HALF) : 1;

  mode_t           mode_q, mode_n;
  logic [HH_W-1:0] hh_q, hh_n;
  logic [MS_W-1:0] mm_q, mm_n, ss_q, ss_n;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_n;
  logic            phase_q, phase_n;
  logic [2:0]      blank_q, blank_n;
  logic            day_q, day_n;
  logic            mode_key_q;

  logic inc_step, dec_step;
  logic mode_press, inc_ok, dec_ok, edit;

  key_repeat #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_inc (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_key  (i_key_inc),
    .o_step (inc_step)
  );

  key_repeat #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_dec (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_key  (i_key_dec),
    .o_step (dec_step)
  );

  // A mode press overrides steps; opposing steps in one cycle cancel.
  assign mode_press = i_key_mode & ~mode_key_q;
  assign inc_ok     = inc_step & ~dec_step & ~mode_press;
  assign dec_ok     = dec_step & ~inc_step & ~mode_press;
  assign edit       = (mode_q != MODE_RUN) & (inc_ok | dec_ok);

  // State register for mode, time fields, blink and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode_q      <= MODE_RUN;
      hh_q        <= '0;
      mm_q        <= '0;
      ss_q        <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      blank_q     <= '0;
      day_q       <= 1'b0;
      mode_key_q  <= 1'b0;
    end else begin
      mode_q      <= mode_n;
      hh_q        <= hh_n;
      mm_q        <= mm_n;
      ss_q        <= ss_n;
      blink_cnt_q <= blink_cnt_n;
      phase_q     <= phase_n;
      blank_q     <= blank_n;
      day_q       <= day_n;
      mode_key_q  <= i_key_mode;
    end
  end

  // Next-state: mode sequencing, time counting or field edit, blink timing.
  always_comb begin
    mode_n      = mode_q;
    hh_n        = hh_q;
    mm_n        = mm_q;
    ss_n        = ss_q;
    day_n       = 1'b0;
    blink_cnt_n = blink_cnt_q;
    phase_n     = phase_q;
    blank_n     = '0;

    // A tick coinciding with a mode press is dropped: the new mode rules.
    if (mode_press) begin
      mode_n = next_mode(mode_q);
    end else begin
      case (mode_q)
        MODE_RUN: begin
          if (i_tick_1hz) begin
            if (ss_q == MS_W'(SS_MAX)) begin
              ss_n = '0;
              if (mm_q == MS_W'(MM_MAX)) begin
                mm_n = '0;
                if (hh_q == HH_W'(HH_MAX)) begin
                  hh_n  = '0;
                  day_n = 1'b1;
                end else begin
                  hh_n = hh_q + HH_W'(1);
                end
              end else begin
                mm_n = mm_q + MS_W'(1);
              end
            end else begin
              ss_n = ss_q + MS_W'(1);
            end
          end
        end
        MODE_SET_HH: if (edit) hh_n = step_hh(hh_q, inc_ok);
        MODE_SET_MM: if (edit) mm_n = step_ms(mm_q, MS_W'(MM_MAX), inc_ok);
        default:     if (edit) ss_n = step_ms(ss_q, MS_W'(SS_MAX), inc_ok);
      endcase
    end

    if (mode_press || edit) begin
      blink_cnt_n = '0;
      phase_n     = 1'b0;
    end else if (blink_cnt_q == BW'(HALF - 1)) begin
      blink_cnt_n = '0;
      phase_n     = ~phase_q;
    end else begin
      blink_cnt_n = blink_cnt_q + BW'(1);
    end

    case (mode_n)
      MODE_SET_HH: blank_n = {phase_n, 2'b00};
      MODE_SET_MM: blank_n = {1'b0, phase_n, 1'b0};
      MODE_SET_SS: blank_n = {2'b00, phase_n};
      default:     blank_n = '0;
    endcase
  end

  assign o_hh        = hh_q;
  assign o_mm        = mm_q;
  assign o_ss        = ss_q;
  assign o_mode      = mode_q;
  assign o_blank     = blank_q;
  assign o_day_pulse = day_q;

endmodule
